greater_than_sweep: RTL

GREATER_THAN_SWEEP -- requirements
Module: greater_than_sweep

---
 rtl/greater_than_sweep.sv | 134 +++++++++++++
 1 files changed

// File: rtl/greater_than_sweep.sv
// Self-test sequencer for a 2-bit greater-than comparator: drives all 16 operand
// pairs, samples the comparator answer for each and scores it against A > B.
module greater_than_sweep #(
    parameter int unsigned HOLD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic [1:0]  a_out,
    output logic [1:0]  b_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  err_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    // Reference answer for vector index v: upper pair is A, lower pair is B.
    function automatic logic expected_gt(input logic [3:0] v);
        return (v[3:2] > v[1:0]);
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic [3:0]  hold_r, hold_s;
    logic [15:0] result_s;
    logic [4:0]  err_s;
    logic        pass_s;
    logic        busy_s;
    logic        done_s;
    logic [1:0]  a_s;
    logic [1:0]  b_s;

    // Next-state, sweep bookkeeping and output decode.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        hold_s   = hold_r;
        result_s = result;
        err_s    = err_cnt;
        pass_s   = pass;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = DRIVE;
                    idx_s    = 4'd0;
                    hold_s   = 4'd0;
                    result_s = 16'h0000;
                    err_s    = 5'd0;
                    pass_s   = 1'b0;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRIVE: begin
                if (hold_r == HOLD_LAST) begin
                    result_s[idx_r] = f_in;
                    // At most 16 increments per sweep, so 5 bits never wrap.
                    if (f_in != expected_gt(idx_r)) begin
                        err_s = err_cnt + 5'd1;
                    end else begin
                        err_s = err_cnt;
                    end
                    hold_s = 4'd0;
                    if (idx_r == 4'd15) begin
                        state_s = DONE;
                        pass_s  = (err_s == 5'd0);
                    end else begin
                        idx_s   = idx_r + 4'd1;
                    end
                end else begin
                    hold_s = hold_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = 4'd0;
                hold_s  = 4'd0;
            end
            default: begin
                state_s = IDLE;
                idx_s   = 4'd0;
                hold_s  = 4'd0;
            end
        endcase

        busy_s = (state_s == DRIVE);
        done_s = (state_s == DONE);
        if (busy_s) begin
            a_s = idx_s[3:2];
            b_s = idx_s[1:0];
        end else begin
            a_s = 2'd0;
            b_s = 2'd0;
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            hold_r  <= 4'd0;
            a_out   <= 2'd0;
            b_out   <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 16'h0000;
            err_cnt <= 5'd0;
            pass    <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            hold_r  <= hold_s;
            a_out   <= a_s;
            b_out   <= b_s;
            busy    <= busy_s;
            done    <= done_s;
            result  <= result_s;
            err_cnt <= err_s;
            pass    <= pass_s;
        end
    end

endmodule
